// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: load/store op codes, FSM state and access-size helpers shared by the LSU files
package mem_lsu_pkg;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

    function automatic size_t op_size(input logic [7:0] op);
        return (op inside {EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP}) ? SZ_B :
               (op inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP}) ? SZ_H :
               (op inside {EXE_LW_OP, EXE_SW_OP})             ? SZ_W : SZ_NONE;
    endfunction

    function automatic logic op_load(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    endfunction

    function automatic logic op_signed(input logic [7:0] op);
        return op inside {EXE_LB_OP, EXE_LH_OP};
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: data bus between the LSU (master) and memory (slave)
//   req/we/addr/sel/wdata : master -> slave, registered request held until ack
//   ack/rdata             : slave -> master, one-cycle completion strobe with read data
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, sel, wdata, input ack, rdata);
    modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_lsu_lane.sv
// lsu_lane: combinational byte-lane mapping for loads and stores
//   op/off/reg2 -> sel/wdata : lane enables and lane-replicated store data
//   op/off/rdata -> ldata    : selected byte/half of read data, sign- or zero-extended
module lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [7:0]  op,
    input  logic [1:0]  off,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] ldata
);
    size_t       sz;
    logic [1:0]  lane;
    logic        hi;
    logic        sx;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sz = op_size(op);
        sx = op_signed(op);
        // lane: physical byte lane (0 = bits [7:0]) addressed by off
        lane = BIG_ENDIAN ? 2'd3 - off : off;
        hi = BIG_ENDIAN ? ~off[1] : off[1];
        b = 8'(rdata >> {lane, 3'b000});
        h = hi ? rdata[31:16] : rdata[15:0];
        sel = sz == SZ_B ? 4'b0001 << lane :
              sz == SZ_H ? (hi ? 4'b1100 : 4'b0011) :
              sz == SZ_W ? 4'b1111 : 4'b0000;
        wdata = sz == SZ_B ? {4{reg2[7:0]}} : sz == SZ_H ? {2{reg2[15:0]}} : reg2;
        ldata = sz == SZ_B ? {{24{sx & b[7]}}, b} :
                sz == SZ_H ? {{16{sx & h[15]}}, h} : rdata;
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-access pipeline stage; runs loads/stores on the data bus and stalls while busy
//   clk, rst                          : clock, synchronous active-high reset
//   flush                             : pipeline flush from ctrl
//   ex_wd/ex_wreg/ex_wdata            : ex/mem destination, write enable, ALU result
//   ex_aluop/ex_mem_addr/ex_reg2      : op code, effective address, store data
//   mem_wd/mem_wreg/mem_wdata         : to mem/wb register
//   stall_req                         : hold ex/mem and earlier stages
//   misalign, bus_err                 : one-cycle pulses (misaligned access, timeout abort)
//   bus                               : data bus master port
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stall_req,
    output logic        misalign,
    output logic        bus_err,
    mem_lsu_if.master   bus
);
    state_t      state, nxt;
    size_t       sz;
    logic [15:0] cnt;
    logic [31:0] rbuf;
    logic        drop, skip, err;
    logic        mem_op, mis, go, tmo, drain, load;
    logic [3:0]  sel;
    logic [31:0] wdata, ldata;

    lsu_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
        .op    (ex_aluop),
        .off   (ex_mem_addr[1:0]),
        .reg2  (ex_reg2),
        .rdata (rbuf),
        .sel   (sel),
        .wdata (wdata),
        .ldata (ldata)
    );

    always_comb begin
        sz = op_size(ex_aluop);
        load = op_load(ex_aluop);
        mem_op = sz != SZ_NONE;
        mis = (sz == SZ_H && ex_mem_addr[0]) || (sz == SZ_W && ex_mem_addr[1:0] != 2'b00);
        // skip: the op still on ex_* is the one that just timed out; retire it without reissuing
        go = state == IDLE && mem_op && !mis && !flush && !skip;
        tmo = TIMEOUT_CYC != 0 && cnt == 16'(TIMEOUT_CYC - 1);
        drain = drop || flush;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? BUSY : IDLE;
            BUSY:    nxt = bus.ack ? (drain ? IDLE : DONE) : tmo ? IDLE : BUSY;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_wd = rst ? 5'd0 : ex_wd;
        mem_wdata = rst ? 32'd0 : (state == DONE && load) ? ldata : ex_wdata;
        mem_wreg = !rst && !flush && ex_wreg && (state == DONE ? load : state == IDLE && !mem_op);
        stall_req = !rst && !flush && (go || (state == BUSY && !drop));
        misalign = !rst && !flush && state == IDLE && mem_op && mis;
        bus_err = !rst && err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= '0;
            bus.sel <= '0;
            bus.wdata <= '0;
            cnt <= '0;
            rbuf <= '0;
            drop <= 1'b0;
            skip <= 1'b0;
            err <= 1'b0;
        end else begin
            err <= state == BUSY && !bus.ack && tmo;
            skip <= state == BUSY && !bus.ack && tmo && !drain;
            if (go) begin
                bus.req <= 1'b1;
                bus.we <= !load;
                bus.addr <= {ex_mem_addr[31:2], 2'b00};
                bus.sel <= sel;
                bus.wdata <= wdata;
                cnt <= '0;
                drop <= 1'b0;
            end else if (state == BUSY) begin
                cnt <= cnt + 16'd1;
                drop <= drain;
                if (bus.ack) rbuf <= bus.rdata;
                if (bus.ack || tmo) bus.req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven vectors plus hand sequences for timeout, flush drain and reset in BUSY
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam logic [7:0] NOP_OP = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  ex_wd, mem_wd;
    logic        ex_wreg, mem_wreg, stall_req, misalign, bus_err;
    logic [31:0] ex_wdata, ex_mem_addr, ex_reg2, mem_wdata;
    logic [7:0]  ex_aluop;

    mem_lsu_if bus();

    mem_lsu #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYC(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .ex_wd       (ex_wd),
        .ex_wreg     (ex_wreg),
        .ex_wdata    (ex_wdata),
        .ex_aluop    (ex_aluop),
        .ex_mem_addr (ex_mem_addr),
        .ex_reg2     (ex_reg2),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .stall_req   (stall_req),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        ex_aluop = op;
        ex_mem_addr = addr;
        ex_reg2 = reg2;
        ex_wd = wd;
        ex_wreg = wreg;
        ex_wdata = wdata;
    endtask

    // kind: 0 = non-memory pass-through, 1 = aligned access with 1-cycle ack, 2 = misaligned
    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        int          kind;
        logic [3:0]  sel;
        logic [31:0] bwd;
        logic [31:0] res;
        logic        wreg;
        logic        we;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                                input logic [31:0] rdata, input int kind, input logic [3:0] sel,
                                input logic [31:0] bwd, input logic [31:0] res, input logic wreg,
                                input logic we);
        mk.op = op; mk.addr = addr; mk.reg2 = reg2; mk.rdata = rdata; mk.kind = kind;
        mk.sel = sel; mk.bwd = bwd; mk.res = res; mk.wreg = wreg; mk.we = we;
    endfunction

    vec_t v[16];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        v[0]  = mk(NOP_OP,     32'h0,   32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);
        v[1]  = mk(EXE_LB_OP,  32'h101, 32'h0,        32'h11F23344, 1, 4'b0100, 32'h0,        32'hFFFFFFF2, 1'b1, 1'b0);
        v[2]  = mk(EXE_LBU_OP, 32'h103, 32'h0,        32'h11F233A4, 1, 4'b0001, 32'h0,        32'h000000A4, 1'b1, 1'b0);
        v[3]  = mk(EXE_LB_OP,  32'h100, 32'h0,        32'h7F000080, 1, 4'b1000, 32'h0,        32'h0000007F, 1'b1, 1'b0);
        v[4]  = mk(EXE_LH_OP,  32'h200, 32'h0,        32'h80017FFF, 1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b1, 1'b0);
        v[5]  = mk(EXE_LHU_OP, 32'h10,  32'h0,        32'h80010000, 1, 4'b1100, 32'h0,        32'h00008001, 1'b1, 1'b0);
        v[6]  = mk(EXE_LH_OP,  32'h12,  32'h0,        32'h1234F00F, 1, 4'b0011, 32'h0,        32'hFFFFF00F, 1'b1, 1'b0);
        v[7]  = mk(EXE_LW_OP,  32'h300, 32'h0,        32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0);
        v[8]  = mk(EXE_SB_OP,  32'h102, 32'h123456AB, 32'h0,        1, 4'b0010, 32'hABABABAB, 32'h0,        1'b0, 1'b1);
        v[9]  = mk(EXE_SH_OP,  32'h202, 32'hAAAABEEF, 32'h0,        1, 4'b0011, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b1);
        v[10] = mk(EXE_SW_OP,  32'h304, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1);
        v[11] = mk(EXE_LW_OP,  32'h301, 32'h0,        32'h0,        2, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
        v[12] = mk(EXE_LH_OP,  32'h203, 32'h0,        32'h0,        2, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
        v[13] = mk(EXE_SW_OP,  32'h302, 32'h0,        32'h0,        2, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
        v[14] = mk(EXE_SH_OP,  32'h201, 32'h0,        32'h0,        2, 4'b0000, 32'h0,        32'h0,        1'b0, 1'b0);
        v[15] = mk(NOP_OP,     32'h303, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0);

        rst = 1'b1;
        flush = 1'b0;
        bus.ack = 1'b0;
        bus.rdata = '0;
        drive(EXE_LB_OP, 32'h101, 32'h55, 5'd7, 1'b1, 32'hFFFF);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_stall", stall_req, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_mem_wreg", mem_wreg, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_bus_req", bus.req, 0);
        chk("rst_bus_we", bus.we, 0);
        chk("rst_bus_addr", bus.addr, 0);
        chk("rst_bus_sel", bus.sel, 0);
        chk("rst_bus_wdata", bus.wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(v[i].op, v[i].addr, v[i].reg2, 5'(i + 1), 1'b1, 32'h1234 + i);
            #1;
            case (v[i].kind)
                0: begin
                    chk($sformatf("v%0d_pass_wd", i), mem_wd, i + 1);
                    chk($sformatf("v%0d_pass_wreg", i), mem_wreg, 1);
                    chk($sformatf("v%0d_pass_wdata", i), mem_wdata, 32'h1234 + i);
                    chk($sformatf("v%0d_pass_stall", i), stall_req, 0);
                    chk($sformatf("v%0d_pass_misalign", i), misalign, 0);
                    @(negedge clk);
                    #1;
                    chk($sformatf("v%0d_pass_bus_req", i), bus.req, 0);
                end
                1: begin
                    chk($sformatf("v%0d_c0_stall", i), stall_req, 1);
                    chk($sformatf("v%0d_c0_wreg", i), mem_wreg, 0);
                    chk($sformatf("v%0d_c0_misalign", i), misalign, 0);
                    @(negedge clk);
                    #1;
                    chk($sformatf("v%0d_c1_stall", i), stall_req, 1);
                    chk($sformatf("v%0d_bus_req", i), bus.req, 1);
                    chk($sformatf("v%0d_bus_we", i), bus.we, v[i].we);
                    chk($sformatf("v%0d_bus_addr", i), bus.addr, {v[i].addr[31:2], 2'b00});
                    chk($sformatf("v%0d_bus_sel", i), bus.sel, v[i].sel);
                    if (v[i].we) chk($sformatf("v%0d_bus_wdata", i), bus.wdata, v[i].bwd);
                    bus.ack = 1'b1;
                    bus.rdata = v[i].rdata;
                    @(negedge clk);
                    bus.ack = 1'b0;
                    bus.rdata = '0;
                    #1;
                    chk($sformatf("v%0d_done_stall", i), stall_req, 0);
                    chk($sformatf("v%0d_done_bus_req", i), bus.req, 0);
                    chk($sformatf("v%0d_done_wreg", i), mem_wreg, v[i].wreg);
                    chk($sformatf("v%0d_done_wd", i), mem_wd, i + 1);
                    if (v[i].wreg) chk($sformatf("v%0d_done_wdata", i), mem_wdata, v[i].res);
                end
                default: begin
                    chk($sformatf("v%0d_mis_pulse", i), misalign, 1);
                    chk($sformatf("v%0d_mis_stall", i), stall_req, 0);
                    chk($sformatf("v%0d_mis_wreg", i), mem_wreg, 0);
                    @(negedge clk);
                    #1;
                    chk($sformatf("v%0d_mis_bus_req", i), bus.req, 0);
                    drive(NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
                    #1;
                    chk($sformatf("v%0d_mis_clear", i), misalign, 0);
                end
            endcase
        end

        // timeout: ack withheld for a LW
        @(negedge clk);
        drive(EXE_LW_OP, 32'h400, 32'h0, 5'd3, 1'b1, 32'h0);
        #1;
        chk("to_c0_stall", stall_req, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to_busy%0d_req", k), bus.req, 1);
            chk($sformatf("to_busy%0d_stall", k), stall_req, 1);
            chk($sformatf("to_busy%0d_err", k), bus_err, 0);
        end
        @(negedge clk);
        #1;
        chk("to_err_pulse", bus_err, 1);
        chk("to_req_drop", bus.req, 0);
        chk("to_stall_rel", stall_req, 0);
        chk("to_wreg", mem_wreg, 0);
        @(negedge clk);
        drive(NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        chk("to_err_clear", bus_err, 0);
        chk("to_no_reissue", bus.req, 0);

        // flush during BUSY: request drains, data discarded, back to IDLE
        @(negedge clk);
        drive(EXE_LHU_OP, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0);
        #1;
        chk("fl_c0_stall", stall_req, 1);
        @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_busy_req", bus.req, 1);
        chk("fl_busy_stall", stall_req, 0);
        chk("fl_busy_wreg", mem_wreg, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_drain1_req", bus.req, 1);
        chk("fl_drain1_stall", stall_req, 0);
        chk("fl_drain1_wreg", mem_wreg, 0);
        @(negedge clk);
        #1;
        chk("fl_drain2_req", bus.req, 1);
        chk("fl_drain2_stall", stall_req, 0);
        @(negedge clk);
        bus.ack = 1'b1;
        bus.rdata = 32'h80010000;
        #1;
        chk("fl_ack_wreg", mem_wreg, 0);
        chk("fl_ack_stall", stall_req, 0);
        @(negedge clk);
        bus.ack = 1'b0;
        bus.rdata = '0;
        #1;
        chk("fl_idle_req", bus.req, 0);
        chk("fl_idle_stall", stall_req, 1);
        chk("fl_idle_wreg", mem_wreg, 0);

        // reset while BUSY (the reissued LHU), then a late ack in IDLE
        @(negedge clk);
        #1;
        chk("rb_busy_req", bus.req, 1);
        rst = 1'b1;
        #1;
        chk("rb_rst_stall", stall_req, 0);
        chk("rb_rst_wreg", mem_wreg, 0);
        chk("rb_rst_wd", mem_wd, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(NOP_OP, 32'h0, 32'h0, 5'd4, 1'b1, 32'h77);
        bus.ack = 1'b1;
        bus.rdata = 32'h80010000;
        #1;
        chk("rb_req_drop", bus.req, 0);
        chk("rb_late_wreg", mem_wreg, 1);
        chk("rb_late_wdata", mem_wdata, 32'h77);
        @(negedge clk);
        bus.ack = 1'b0;
        bus.rdata = '0;
        drive(EXE_LHU_OP, 32'h10, 32'h0, 5'd9, 1'b1, 32'h0);
        #1;
        chk("rb_ack_ignored_stall", stall_req, 1);
        chk("rb_ack_ignored_req", bus.req, 0);
        @(negedge clk);
        #1;
        chk("rb_reissue_req", bus.req, 1);
        bus.ack = 1'b1;
        bus.rdata = 32'h80010000;
        @(negedge clk);
        bus.ack = 1'b0;
        bus.rdata = '0;
        #1;
        chk("rb_lhu_wreg", mem_wreg, 1);
        chk("rb_lhu_wdata", mem_wdata, 32'h00008001);
        chk("rb_lhu_stall", stall_req, 0);
        @(negedge clk);
        drive(NOP_OP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
